// File: rtl/seg_arbiter.sv
// seg_arbiter: two-requester ownership arbiter for an eight-digit, active-low
// seven-segment display. The owner keeps the display for at least HOLD_CYCLES
// cycles unless it releases early; the registered segment path shows the
// current owner's hex value with per-digit blanking.
module seg_arbiter #(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] val0,
    input  logic [31:0] val1,
    input  logic [7:0]  en0,
    input  logic [7:0]  en1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7
);

    localparam int                CNT_W   = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last;
    logic                r_gnt0;
    logic                r_gnt1;
    logic [7:0][7:0]     r_seg;
    logic                w_sat;
    logic [31:0]         w_val;
    logic [7:0]          w_en;

    // Hex nibble to active-low segments (bit0..6 = a..g, dp kept off).
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            4'hF:    s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Next-state arbitration: release beats hold, hold expiry yields to the other requester.
    always_comb begin
        w_next = r_state;
        w_sat  = (r_cnt == CNT_MAX);
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_next = r_last ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    w_next = ST_OWN0;
                end else if (req1) begin
                    w_next = ST_OWN1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    w_next = req1 ? ST_OWN1 : ST_IDLE;
                end else if (w_sat && req1) begin
                    w_next = ST_OWN1;
                end else begin
                    w_next = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!req1) begin
                    w_next = req0 ? ST_OWN0 : ST_IDLE;
                end else if (w_sat && req0) begin
                    w_next = ST_OWN0;
                end else begin
                    w_next = ST_OWN1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State, grant, hold counter and last-served pointer; counter restarts on every new ownership.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_last  <= 1'b1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gnt0  <= (w_next == ST_OWN0);
            r_gnt1  <= (w_next == ST_OWN1);
            if ((w_next != r_state) && (w_next != ST_IDLE)) begin
                r_cnt  <= {CNT_W{1'b0}};
                r_last <= (w_next == ST_OWN1);
            end else if ((w_next == r_state) && (r_state != ST_IDLE) && !w_sat) begin
                r_cnt  <= r_cnt + 1'b1;
            end else begin
                r_cnt  <= r_cnt;
            end
        end
    end

    // Select the display source from the owner before the edge; no owner means all digits blank.
    always_comb begin
        w_val = 32'h0000_0000;
        w_en  = 8'h00;
        case (r_state)
            ST_OWN0: begin
                w_val = val0;
                w_en  = en0;
            end
            ST_OWN1: begin
                w_val = val1;
                w_en  = en1;
            end
            default: begin
                w_val = 32'h0000_0000;
                w_en  = 8'h00;
            end
        endcase
    end

    // Registered segment drivers: decoded nibble when the digit is enabled, otherwise dark.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seg <= {8{8'hFF}};
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_seg[i] <= w_en[i] ? hex_to_seg(w_val[4*i +: 4]) : 8'hFF;
            end
        end
    end

    assign gnt0 = r_gnt0;
    assign gnt1 = r_gnt1;
    assign seg0 = r_seg[0];
    assign seg1 = r_seg[1];
    assign seg2 = r_seg[2];
    assign seg3 = r_seg[3];
    assign seg4 = r_seg[4];
    assign seg5 = r_seg[5];
    assign seg6 = r_seg[6];
    assign seg7 = r_seg[7];

endmodule

// File: doc/seg_arbiter.md
SEG_ARBITER -- requirements
Module: seg_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1000: minimum cycles an owner keeps the display before pre-emption; legal range >= 1.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0, req1  input  1 each  display request from requester 0 / 1; level-held while display wanted.
REQ-005 SHALL have ports val0, val1  input  32 each  eight hex nibbles; nibble i = val[4i+3:4i] drives digit i.
REQ-006 SHALL have ports en0, en1  input  8 each  per-digit enable; bit i = 0 blanks digit i.
REQ-007 SHALL have ports gnt0, gnt1  output  1 each  registered grant to requester 0 / 1.
REQ-008 SHALL have ports seg0..seg7  output  8 each  registered, active-low segments; bit0..bit6 = a..g, bit7 = dp; 1 = segment off.

Function
REQ-009 SHALL implement states IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1); gnt0 and gnt1 never both 1.
REQ-010 SHALL hold a last-served pointer LAST (0/1) and a hold counter CNT, width ceil(log2(HOLD_CYCLES+1)).
REQ-011 IDLE: neither req -> stay IDLE; one req -> that owner; both -> requester != LAST; grant visible after the edge sampling the req (1-cycle latency).
REQ-012 On every entry into OWNx: CNT <= 0, LAST <= x.
REQ-013 OWNx, CNT < HOLD_CYCLES-1: CNT increments by 1 per cycle.
REQ-014 OWNx, CNT == HOLD_CYCLES-1: CNT saturates; other req high -> direct switch to other owner at that edge, no IDLE cycle.
REQ-015 OWNx, reqx low: other req high -> direct switch to other owner regardless of CNT; else -> IDLE.
REQ-016 Release (REQ-015) SHALL take precedence over hold; with HOLD_CYCLES = 1 and both req high, ownership SHALL alternate every cycle.
REQ-017 Display path registered: each edge, seg_i <= decode(owner val nibble i) if owner en[i]=1, else 8'hFF; owner = state value before the edge.
REQ-018 State IDLE before the edge -> all seg_i <= 8'hFF.
REQ-019 Display latency: req sampled at edge N -> gnt at N -> seg reflects that requester's val/en at edge N+1; val/en changes during ownership appear on seg one edge later.
REQ-020 Decode table (hex -> seg, dp always off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-021 Non-owner val/en SHALL never affect seg outputs.
REQ-022 Requester dropping req while not granted SHALL leave state, CNT and LAST unchanged.

Reset
REQ-023 resetn low SHALL immediately (no clock) force state IDLE, gnt0=gnt1=0, CNT=0, LAST=1, all seg_i = 8'hFF.
REQ-024 Reset mid-ownership SHALL discard ownership; first post-reset arbitration with both req high grants requester 0.
REQ-025 After resetn rises, the first rising edge SHALL perform normal IDLE arbitration.

Verification
REQ-026 Reset, then req0=1, val0=32'h76543210, en0=8'hFF -> gnt0=1 after edge 1; after edge 2 seg0..seg7 = C0,F9,A4,B0,99,92,82,F8.
REQ-027 HOLD_CYCLES=4; both req from reset -> gnt0 for 4 cycles, then gnt1 for 4 cycles, alternating; gnt0 & gnt1 never both 1.
REQ-028 Owner 1, en1=8'h0F, val1=32'hFEDCBA98 -> seg0..3 = 80,90,88,83; seg4..7 = FF.
REQ-029 Owner 0 at CNT=1 (HOLD_CYCLES=1000), req0 drops with req1 high -> gnt1=1 on next edge with no IDLE cycle; with req1 low -> IDLE, all seg = FF one edge later.
REQ-030 resetn pulsed low mid-cycle while gnt1=1 -> gnt1 and all seg go to 0/FF without a clock edge; after release with both req high -> gnt0 first.
